// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue unit.
// Widths, opcode limit and sequencer state encoding.
package alu_pkg;

  localparam int DW         = 4;
  localparam int OPW        = 3;
  localparam int NREG       = 4;
  localparam int RIW        = $clog2(NREG);
  localparam int ALU_OP_MAX = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction handshake bundle for the ALU issue unit.
// Master is the upstream producer; slave is the issue unit.
interface alu_issue_unit_if #(
  parameter int DW  = alu_pkg::DW,
  parameter int OPW = alu_pkg::OPW,
  parameter int IW  = alu_pkg::RIW
);

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic           in_ld;
  logic           in_imm_en;
  logic [DW-1:0]  in_imm;
  logic [IW-1:0]  in_rd;
  logic [IW-1:0]  in_ra;
  logic [IW-1:0]  in_rb;

  modport master (
    output in_valid,
    output in_op,
    output in_ld,
    output in_imm_en,
    output in_imm,
    output in_rd,
    output in_ra,
    output in_rb,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_ld,
    input  in_imm_en,
    input  in_imm,
    input  in_rd,
    input  in_ra,
    input  in_rb,
    output in_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// Small register file: two read ports, a debug read port
// and one synchronous write port, all cleared on reset.
module alu_regfile #(
  parameter int DW   = 4,
  parameter int NREG = 4,
  parameter int IW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] ra,
  output logic [DW-1:0] rdata_a,
  input  logic [IW-1:0] rb,
  output logic [DW-1:0] rdata_b,
  input  logic [IW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] rf [NREG];

  // Storage with async clear and a single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata_a  = rf[ra];
  assign rdata_b  = rf[rb];
  assign dbg_data = rf[dbg_sel];

endmodule

// File: rtl/alu_issue_unit.sv
// Serialising sequencer feeding a combinational ALU:
// operand fetch, one settle cycle, then result writeback.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DW   = alu_pkg::DW,
  parameter int NREG = alu_pkg::NREG,
  parameter int OPW  = alu_pkg::OPW
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_issue_unit_if.slave       req,
  output logic [DW-1:0]         Ain,
  output logic [DW-1:0]         Bin,
  output logic [OPW-1:0]        ALUop,
  input  logic [DW-1:0]         ALUout,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            op_count,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [DW-1:0]         dbg_data
);

  localparam int IW = $clog2(NREG);

  state_t        state;
  logic [IW-1:0] rd_q;
  logic          fire;
  logic          illegal;
  logic          we;
  logic [IW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;

  assign req.in_ready = (state == S_IDLE);
  assign fire    = req.in_valid && req.in_ready;
  assign illegal = req.in_op > OPW'(ALU_OP_MAX);

  // Write port: immediate on load accept, ALU result in WB
  always_comb begin
    we    = 1'b0;
    waddr = req.in_rd;
    wdata = req.in_imm;
    if (state == S_WB) begin
      we    = 1'b1;
      waddr = rd_q;
      wdata = ALUout;
    end else if (fire && req.in_ld) begin
      we    = 1'b1;
    end
  end

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .IW   (IW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .ra       (req.in_ra),
    .rdata_a  (rdata_a),
    .rb       (req.in_rb),
    .rdata_b  (rdata_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // Sequencer, operand registers, status pulses and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      Ain      <= '0;
      Bin      <= '0;
      ALUop    <= '0;
      rd_q     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      op_count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fire) begin
            if (req.in_ld) begin
              done <= 1'b1;
            end else if (illegal) begin
              err <= 1'b1;
            end else begin
              Ain   <= rdata_a;
              Bin   <= req.in_imm_en ? req.in_imm : rdata_b;
              ALUop <= req.in_op;
              rd_q  <= req.in_rd;
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state <= S_WB;
        end
        S_WB: begin
          done     <= 1'b1;
          op_count <= op_count + 8'd1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a
// behavioural 4-bit ALU closing the loop on ALUout.
module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Ain, Bin, ALUout, dbg_data;
  logic [2:0] ALUop;
  logic       done, err;
  logic [7:0] op_count;
  logic [1:0] dbg_sel;

  int checks = 0;
  int errors = 0;

  alu_issue_unit_if #(.DW(4), .OPW(3), .IW(2)) bus ();

  alu_issue_unit dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .Ain      (Ain),
    .Bin      (Bin),
    .ALUop    (ALUop),
    .ALUout   (ALUout),
    .done     (done),
    .err      (err),
    .op_count (op_count),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      default: return 4'd0;
    endcase
  endfunction

  assign ALUout = alu_f(ALUop, Ain, Bin);

  typedef struct {
    logic       ld;
    logic       imm_en;
    logic [2:0] op;
    logic [3:0] imm;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       exp_done;
    logic       exp_err;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_rd;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic alu;
    alu = !v.ld && (v.op <= 3'd5);
    bus.in_ld     = v.ld;
    bus.in_imm_en = v.imm_en;
    bus.in_op     = v.op;
    bus.in_imm    = v.imm;
    bus.in_rd     = v.rd;
    bus.in_ra     = v.ra;
    bus.in_rb     = v.rb;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (alu) begin
      chk("acc_ready", bus.in_ready, 0);
      chk("Ain", Ain, v.exp_a);
      chk("Bin", Bin, v.exp_b);
      chk("ALUop", ALUop, v.op);
      @(posedge clk);
      #1;
      chk("exec_done", done, 0);
      chk("exec_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    chk("done", done, v.exp_done);
    chk("err", err, v.exp_err);
    chk("ready", bus.in_ready, 1);
    dbg_sel = v.rd;
    #1;
    chk("rd_val", dbg_data, v.exp_rd);
    chk("op_count", op_count, v.exp_cnt);
  endtask

  initial begin
    vec_t v;
    logic [3:0] a, b;
    logic [7:0] cnt;

    tbl[0] = '{1, 0, 3'd0, 4'd15, 2'd1, 2'd0, 2'd0,
               1, 0, 4'd0, 4'd0, 4'd15, 8'd0};
    tbl[1] = '{1, 0, 3'd0, 4'd0, 2'd2, 2'd0, 2'd0,
               1, 0, 4'd0, 4'd0, 4'd0, 8'd0};
    tbl[2] = '{0, 0, 3'd0, 4'd0, 2'd3, 2'd1, 2'd2,
               1, 0, 4'd15, 4'd0, 4'd15, 8'd1};
    tbl[3] = '{0, 1, 3'd0, 4'd1, 2'd1, 2'd1, 2'd0,
               1, 0, 4'd15, 4'd1, 4'd0, 8'd2};
    tbl[4] = '{0, 0, 3'd6, 4'd9, 2'd1, 2'd3, 2'd3,
               0, 1, 4'd0, 4'd0, 4'd0, 8'd2};
    tbl[5] = '{0, 0, 3'd7, 4'd9, 2'd3, 2'd1, 2'd1,
               0, 1, 4'd0, 4'd0, 4'd15, 8'd2};
    tbl[6] = '{1, 0, 3'd7, 4'd9, 2'd0, 2'd0, 2'd0,
               1, 0, 4'd0, 4'd0, 4'd9, 8'd2};
    tbl[7] = '{0, 0, 3'd1, 4'd0, 2'd2, 2'd3, 2'd0,
               1, 0, 4'd15, 4'd9, 4'd6, 8'd3};
    tbl[8] = '{0, 0, 3'd2, 4'd0, 2'd0, 2'd3, 2'd2,
               1, 0, 4'd15, 4'd6, 4'd6, 8'd4};
    tbl[9] = '{0, 1, 3'd4, 4'd5, 2'd1, 2'd2, 2'd0,
               1, 0, 4'd6, 4'd5, 4'd3, 8'd5};

    bus.in_valid  = 1'b0;
    bus.in_ld     = 1'b0;
    bus.in_imm_en = 1'b0;
    bus.in_op     = '0;
    bus.in_imm    = '0;
    bus.in_rd     = '0;
    bus.in_ra     = '0;
    bus.in_rb     = '0;
    dbg_sel       = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ready", bus.in_ready, 1);
    chk("rst_Ain", Ain, 0);
    chk("rst_Bin", Bin, 0);
    chk("rst_ALUop", ALUop, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", op_count, 0);

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i]);
    end

    // reset while in EXEC: no writeback, everything cleared
    bus.in_ld     = 1'b0;
    bus.in_imm_en = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_rd     = 2'd2;
    bus.in_ra     = 2'd3;
    bus.in_rb     = 2'd0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("exec_entry", bus.in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_Ain", Ain, 0);
    chk("mid_Bin", Bin, 0);
    chk("mid_ALUop", ALUop, 0);
    chk("mid_cnt", op_count, 0);
    chk("mid_ready", bus.in_ready, 1);
    chk("mid_done", done, 0);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      chk("mid_rf", dbg_data, 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_done", done, 0);
    chk("post_cnt", op_count, 0);

    // sweep all legal ops over descending/ascending operands
    cnt = 8'd0;
    for (int op = 0; op < 6; op++) begin
      for (int i = 0; i < 15; i++) begin
        a = 4'(15 - i);
        b = 4'(i);
        v = '{1, 0, 3'd0, a, 2'd1, 2'd0, 2'd0,
              1, 0, 4'd0, 4'd0, a, cnt};
        apply(v);
        v = '{1, 0, 3'd0, b, 2'd2, 2'd0, 2'd0,
              1, 0, 4'd0, 4'd0, b, cnt};
        apply(v);
        cnt = cnt + 8'd1;
        v = '{0, 0, 3'(op), 4'd0, 2'd3, 2'd1, 2'd2,
              1, 0, a, b, alu_f(3'(op), a, b), cnt};
        apply(v);
      end
    end
    chk("sweep_cnt", op_count, 90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // done and err must never coincide
  always @(negedge clk) begin
    if (!rst && done && err) begin
      errors++;
      $display("FAIL done_err_overlap got 1 want 0");
    end
  end

endmodule
